// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-fetch and D load/store requests onto one busywait memory port.
// Optional `define ARB_ROUND_ROBIN_EN: simultaneous requests alternate ports instead of D-first.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              issued_r, issued_nxt_s;
  logic              m_read_r, m_read_nxt_s;
  logic              m_write_r, m_write_nxt_s;
  logic [ADDR_W-1:0] m_addr_r, m_addr_nxt_s;
  logic [DATA_W-1:0] m_wdata_r, m_wdata_nxt_s;
  logic [DATA_W-1:0] i_rdata_r, i_rdata_nxt_s;
  logic [DATA_W-1:0] d_rdata_r, d_rdata_nxt_s;
  logic              req_i_s, req_d_s, pick_d_s, mem_done_s;

  assign req_i_s    = I_READ;
  assign req_d_s    = D_READ | D_WRITE;
  // The strobe must have been held for one edge before memory idle counts as completion.
  assign mem_done_s = issued_r & ~M_BUSYWAIT;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_r;  // 1'b0 = D served last, 1'b1 = I served last
  logic cpl_i_s, cpl_d_s;

  assign cpl_i_s = (state_r == GRANT_I) & mem_done_s;
  assign cpl_d_s = (state_r == GRANT_D) & mem_done_s;

  // Records the port whose access completed most recently.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_grant_r <= 1'b0;
    end else if (cpl_i_s) begin
      last_grant_r <= 1'b1;
    end else if (cpl_d_s) begin
      last_grant_r <= 1'b0;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // On a tie the port not served last wins; a lone requester always wins.
  always_comb begin
    pick_d_s = req_d_s;
    if (req_d_s && req_i_s) begin
      pick_d_s = last_grant_r;
    end else begin
      pick_d_s = req_d_s;
    end
  end
`else
  // Fixed priority: any D request beats an I request.
  always_comb begin
    pick_d_s = req_d_s;
  end
`endif

  // Grant FSM next-state and latched memory-side / read-data values.
  always_comb begin
    state_nxt_s   = state_r;
    issued_nxt_s  = issued_r;
    m_read_nxt_s  = m_read_r;
    m_write_nxt_s = m_write_r;
    m_addr_nxt_s  = m_addr_r;
    m_wdata_nxt_s = m_wdata_r;
    i_rdata_nxt_s = i_rdata_r;
    d_rdata_nxt_s = d_rdata_r;
    case (state_r)
      IDLE: begin
        if (pick_d_s) begin
          state_nxt_s  = GRANT_D;
          issued_nxt_s = 1'b0;
          m_addr_nxt_s = D_ADDR;
          if (D_WRITE) begin
            m_write_nxt_s = 1'b1;
            m_read_nxt_s  = 1'b0;
            m_wdata_nxt_s = D_WRITEDATA;
          end else begin
            m_write_nxt_s = 1'b0;
            m_read_nxt_s  = 1'b1;
          end
        end else if (req_i_s) begin
          state_nxt_s   = GRANT_I;
          issued_nxt_s  = 1'b0;
          m_addr_nxt_s  = I_ADDR;
          m_read_nxt_s  = 1'b1;
          m_write_nxt_s = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT_I: begin
        if (!issued_r) begin
          issued_nxt_s = 1'b1;
        end else if (mem_done_s) begin
          i_rdata_nxt_s = M_READDATA;
          m_read_nxt_s  = 1'b0;
          m_write_nxt_s = 1'b0;
          state_nxt_s   = DONE_I;
        end else begin
          state_nxt_s = GRANT_I;
        end
      end
      GRANT_D: begin
        if (!issued_r) begin
          issued_nxt_s = 1'b1;
        end else if (mem_done_s) begin
          if (m_read_r) begin
            d_rdata_nxt_s = M_READDATA;
          end else begin
            d_rdata_nxt_s = d_rdata_r;
          end
          m_read_nxt_s  = 1'b0;
          m_write_nxt_s = 1'b0;
          state_nxt_s   = DONE_D;
        end else begin
          state_nxt_s = GRANT_D;
        end
      end
      DONE_I: begin
        state_nxt_s = IDLE;
      end
      DONE_D: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s   = IDLE;
        m_read_nxt_s  = 1'b0;
        m_write_nxt_s = 1'b0;
        issued_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= IDLE;
      issued_r  <= 1'b0;
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
      m_addr_r  <= {ADDR_W{1'b0}};
      m_wdata_r <= {DATA_W{1'b0}};
      i_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      issued_r  <= issued_nxt_s;
      m_read_r  <= m_read_nxt_s;
      m_write_r <= m_write_nxt_s;
      m_addr_r  <= m_addr_nxt_s;
      m_wdata_r <= m_wdata_nxt_s;
      i_rdata_r <= i_rdata_nxt_s;
      d_rdata_r <= d_rdata_nxt_s;
    end
  end

  assign M_READ      = m_read_r;
  assign M_WRITE     = m_write_r;
  assign M_ADDR      = m_addr_r;
  assign M_WRITEDATA = m_wdata_r;
  assign I_READDATA  = i_rdata_r;
  assign D_READDATA  = d_rdata_r;
  // Stalls are released only in the requester's own DONE cycle, and never during reset.
  assign I_BUSYWAIT  = ~RESET & req_i_s & (state_r != DONE_I);
  assign D_BUSYWAIT  = ~RESET & req_d_s & (state_r != DONE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized checks of mem_arbiter against a transaction-level
// reference (memory image, service order and latency derived from the arbitration rules).
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_READ, D_READ, D_WRITE;
  logic [AW-1:0] I_ADDR, D_ADDR, M_ADDR;
  logic [DW-1:0] D_WRITEDATA, I_READDATA, D_READDATA, M_WRITEDATA, M_READDATA;
  logic          I_BUSYWAIT, D_BUSYWAIT, M_READ, M_WRITE, M_BUSYWAIT;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDR(M_ADDR), .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 4) return 32'hDEAD_BEEF;
    return (DW'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Main-memory model: busy for 'lat' cycles after a strobe rises.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            mem_ready = 1'b0;
  int            busy_cnt  = 0;
  int            lat       = 0;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (M_WRITE && !M_BUSYWAIT) begin
      mem[M_ADDR] <= M_WRITEDATA;
    end
    if (M_READ || M_WRITE) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
  end
  assign M_BUSYWAIT = (M_READ || M_WRITE) && (busy_cnt < lat);
  assign M_READDATA = mem[M_ADDR];

  // Reference state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_i_rdata, exp_d_rdata;
  bit            last_i;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Edge index (grant edge = 0) on which an access completes for a given memory latency.
  function automatic int cpl_edge(input int l);
    return (l + 1 > 2) ? l + 1 : 2;
  endfunction

  task automatic single_access(input bit is_d, input bit wr, input bit both, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input int l, input bit chg, input bit hold,
                               input string tag);
    int n, strobe_cyc, k;
    bit done;
    k = cpl_edge(l);
    lat = l;
    if (is_d) begin
      D_ADDR = a; D_WRITEDATA = wd; D_WRITE = wr; D_READ = wr ? both : 1'b1;
    end else begin
      I_ADDR = a; I_READ = 1'b1;
    end
    n = 0; strobe_cyc = 0; done = 1'b0;
    while (!done && n < 64) begin
      tick(); n++;
      if (chg && n == 2) begin
        if (is_d) begin D_ADDR = a ^ 10'h030; D_WRITEDATA = ~wd; end
        else I_ADDR = a ^ 10'h030;
      end
      if (M_READ || M_WRITE) begin
        strobe_cyc++;
        chk({tag, "/m_addr"}, DW'(M_ADDR), DW'(a));
        chk({tag, "/m_write"}, DW'(M_WRITE), DW'(is_d && wr));
        chk({tag, "/m_read"}, DW'(M_READ), DW'(!(is_d && wr)));
        if (is_d && wr) chk({tag, "/m_wdata"}, M_WRITEDATA, wd);
      end
      done = is_d ? !D_BUSYWAIT : !I_BUSYWAIT;
    end
    chk({tag, "/latency"}, DW'(n), DW'(k + 1));
    chk({tag, "/strobe_cycles"}, DW'(strobe_cyc), DW'(k));
    chk({tag, "/strobes_in_done"}, DW'({M_READ, M_WRITE}), 32'd0);
    if (is_d) begin
      chk({tag, "/i_bw_idle"}, DW'(I_BUSYWAIT), 32'd0);
      if (wr) ref_mem[a] = wd;
      else exp_d_rdata = ref_mem[a];
    end else begin
      chk({tag, "/d_bw_idle"}, DW'(D_BUSYWAIT), 32'd0);
      exp_i_rdata = ref_mem[a];
    end
    chk({tag, "/d_rdata"}, D_READDATA, exp_d_rdata);
    chk({tag, "/i_rdata"}, I_READDATA, exp_i_rdata);
    last_i = !is_d;
    if (hold) begin
      tick();
      chk({tag, "/new_req_stalls"}, DW'(is_d ? D_BUSYWAIT : I_BUSYWAIT), 32'd1);
      chk({tag, "/idle_strobe"}, DW'(M_READ), 32'd0);
    end
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    tick();
  endtask

  task automatic drop_access(input logic [AW-1:0] a, input int l);
    int k, strobe_cyc;
    k = cpl_edge(l);
    lat = l;
    I_ADDR = a; I_READ = 1'b1;
    strobe_cyc = 0;
    for (int n = 1; n <= k + 1; n++) begin
      tick();
      if (n == 1) begin I_READ = 1'b0; I_ADDR = ~a; end
      else chk("drop/i_bw", DW'(I_BUSYWAIT), 32'd0);
      if (M_READ) strobe_cyc++;
    end
    exp_i_rdata = ref_mem[a];
    chk("drop/strobe_cycles", DW'(strobe_cyc), DW'(k));
    chk("drop/i_rdata", I_READDATA, exp_i_rdata);
    last_i = 1'b1;
    tick();
  endtask

  task automatic contend(input bit d_wr, input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input int l, input string tag);
    int n, ni, nd, k;
    bit d_first;
    k = cpl_edge(l);
    lat = l;
`ifdef ARB_ROUND_ROBIN_EN
    d_first = last_i;
`else
    d_first = 1'b1;
`endif
    I_ADDR = ai; I_READ = 1'b1;
    D_ADDR = ad; D_WRITEDATA = wd; D_WRITE = d_wr; D_READ = !d_wr;
    n = 0; ni = 0; nd = 0;
    while ((ni == 0 || nd == 0) && n < 128) begin
      tick(); n++;
      if (ni == 0 && !I_BUSYWAIT) begin
        ni = n;
        exp_i_rdata = ref_mem[ai];
        chk({tag, "/i_rdata"}, I_READDATA, exp_i_rdata);
        I_READ = 1'b0;
      end
      if (nd == 0 && !D_BUSYWAIT) begin
        nd = n;
        if (d_wr) ref_mem[ad] = wd;
        else exp_d_rdata = ref_mem[ad];
        chk({tag, "/d_rdata"}, D_READDATA, exp_d_rdata);
        D_READ = 1'b0; D_WRITE = 1'b0;
      end
    end
    chk({tag, "/first_served"}, DW'(d_first ? nd : ni), DW'(k + 1));
    chk({tag, "/second_served"}, DW'(d_first ? ni : nd), DW'(2 * k + 3));
    last_i = d_first;
    tick();
  endtask

  initial begin
    int sel, rl;
    logic [AW-1:0] ra, rb;
    logic [DW-1:0] rd;
    RESET = 1'b1;
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    I_ADDR = '0; D_ADDR = '0; D_WRITEDATA = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    exp_i_rdata = '0; exp_d_rdata = '0; last_i = 1'b0;

    // Reset state, with requests present to show stalls are suppressed.
    I_READ = 1'b1; D_READ = 1'b1;
    tick(); tick();
    chk("reset/m_strobes", DW'({M_READ, M_WRITE}), 32'd0);
    chk("reset/m_addr", DW'(M_ADDR), 32'd0);
    chk("reset/m_wdata", M_WRITEDATA, 32'd0);
    chk("reset/i_rdata", I_READDATA, 32'd0);
    chk("reset/d_rdata", D_READDATA, 32'd0);
    chk("reset/busywaits", DW'({I_BUSYWAIT, D_BUSYWAIT}), 32'd0);
    I_READ = 1'b0; D_READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    single_access(1'b0, 1'b0, 1'b0, 10'h004, 32'd0, 3, 1'b0, 1'b1, "i_read");
    chk("i_read/deadbeef", I_READDATA, 32'hDEAD_BEEF);
    single_access(1'b1, 1'b1, 1'b0, 10'h010, 32'h0000_00A5, 2, 1'b1, 1'b0, "d_write_chg");
    single_access(1'b1, 1'b0, 1'b0, 10'h010, 32'd0, 1, 1'b0, 1'b0, "d_read_010");
    chk("d_read_010/a5", D_READDATA, 32'h0000_00A5);
    single_access(1'b1, 1'b0, 1'b0, 10'h020, 32'd0, 0, 1'b0, 1'b0, "d_read_020");
    single_access(1'b1, 1'b1, 1'b1, 10'h0F0, 32'h1234_5678, 0, 1'b0, 1'b1, "d_rw_both");
    contend(1'b0, 10'h004, 10'h0F0, 32'd0, 1, "contend_rr");
    contend(1'b1, 10'h0F0, 10'h0F0, 32'hCAFE_F00D, 2, "contend_rw");
    drop_access(10'h0AB, 2);

    // Asynchronous reset in the middle of an I grant.
    lat = 5;
    I_ADDR = 10'h044; I_READ = 1'b1;
    tick(); tick(); tick();
    chk("rst_mid/pre_m_read", DW'(M_READ), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid/m_read", DW'(M_READ), 32'd0);
    chk("rst_mid/busywaits", DW'({I_BUSYWAIT, D_BUSYWAIT}), 32'd0);
    chk("rst_mid/i_rdata", I_READDATA, 32'd0);
    chk("rst_mid/d_rdata", D_READDATA, 32'd0);
    exp_i_rdata = '0; exp_d_rdata = '0; last_i = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    single_access(1'b0, 1'b0, 1'b0, 10'h044, 32'd0, 5, 1'b0, 1'b0, "rst_restart");

    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 4));
      rl  = int'($urandom_range(0, 4));
      ra  = AW'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 1) == 0) ? ra : AW'($urandom_range(0, 15));
      rd  = DW'($urandom);
      case (sel)
        0: single_access(1'b0, 1'b0, 1'b0, ra, rd, rl, 1'b0, $urandom_range(0, 1) == 1, "rnd_i");
        1: single_access(1'b1, 1'b0, 1'b0, ra, rd, rl, 1'b1, 1'b0, "rnd_dr");
        2: single_access(1'b1, 1'b1, $urandom_range(0, 1) == 1, ra, rd, rl, 1'b1, 1'b0, "rnd_dw");
        3: contend(1'b0, ra, rb, rd, rl, "rnd_con_r");
        default: contend(1'b1, ra, rb, rd, rl, "rnd_con_w");
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
